// File: rtl/overlay_sequencer_pkg.sv
// rtl/overlay_sequencer_pkg.sv - state encoding, default timing and helpers for the overlay sequencer
package overlay_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SLIDE_IN  = 3'd1,
        ST_HOLD      = 3'd2,
        ST_BLINK     = 3'd3,
        ST_SLIDE_OUT = 3'd4,
        ST_GAP       = 3'd5
    } seq_state_e;

    localparam logic [5:0] DEF_TARGET_COL   = 6'd30;
    localparam logic [5:0] DEF_OFF_COL      = 6'd60;
    localparam logic [7:0] DEF_STEP_FRAMES  = 8'd2;
    localparam logic [7:0] DEF_HOLD_FRAMES  = 8'd120;
    localparam logic [7:0] DEF_BLINK_FRAMES = 8'd32;
    localparam logic [7:0] DEF_GAP_FRAMES   = 8'd30;
    localparam logic [1:0] DEF_NUM_MSGS     = 2'd3;

    // Message index advance, wrapping at num_msgs-1 back to 0.
    function automatic logic [1:0] msg_next(input logic [1:0] cur, input logic [1:0] num_msgs);
        if (cur >= num_msgs - 2'd1) begin
            return 2'd0;
        end
        return cur + 2'd1;
    endfunction

endpackage

// File: rtl/overlay_sequencer_if.sv
// rtl/overlay_sequencer_if.sv - frame/run inputs and overlay control outputs of the sequencer
interface overlay_sequencer_if;
    logic       frame_tick;
    logic       run;
    logic [5:0] org_x;
    logic       overlay_en;
    logic [1:0] msg_sel;
    logic       busy;

    modport master (
        input  frame_tick,
        input  run,
        output org_x,
        output overlay_en,
        output msg_sel,
        output busy
    );

    modport slave (
        output frame_tick,
        output run,
        input  org_x,
        input  overlay_en,
        input  msg_sel,
        input  busy
    );
endinterface

// File: rtl/overlay_sequencer_frame_timer.sv
// rtl/overlay_sequencer_frame_timer.sv - 8-bit frame counter with clear and terminal-count compare
module overlay_sequencer_frame_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       clr,
    input  logic [7:0] term,
    output logic [7:0] count,
    output logic       at_term
);
    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (tick) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign at_term = (count_q == term);
endmodule

// File: rtl/overlay_sequencer.sv
// rtl/overlay_sequencer.sv - frame-paced slide-in / hold / blink / slide-out text overlay sequencer
module overlay_sequencer
    import overlay_sequencer_pkg::*;
#(
    parameter logic [5:0] TARGET_COL   = DEF_TARGET_COL,
    parameter logic [5:0] OFF_COL      = DEF_OFF_COL,
    parameter logic [7:0] STEP_FRAMES  = DEF_STEP_FRAMES,
    parameter logic [7:0] HOLD_FRAMES  = DEF_HOLD_FRAMES,
    parameter logic [7:0] BLINK_FRAMES = DEF_BLINK_FRAMES,
    parameter logic [7:0] GAP_FRAMES   = DEF_GAP_FRAMES,
    parameter logic [1:0] NUM_MSGS     = DEF_NUM_MSGS
) (
    input  logic                clk,
    input  logic                reset,
    overlay_sequencer_if.master bus
);
    seq_state_e state_q, state_d;
    logic [5:0] org_x_q, org_x_d;
    logic       overlay_en_q, overlay_en_d;
    logic [1:0] msg_sel_q, msg_sel_d;
    logic       busy_q, busy_d;

    logic       cnt_clr;
    logic [7:0] cnt_term;
    logic [7:0] cnt;
    logic       cnt_at_term;

    overlay_sequencer_frame_timer u_frame_timer (
        .clk     (clk),
        .reset   (reset),
        .tick    (bus.frame_tick),
        .clr     (cnt_clr),
        .term    (cnt_term),
        .count   (cnt),
        .at_term (cnt_at_term)
    );

    always_comb begin
        case (state_q)
            ST_SLIDE_IN, ST_SLIDE_OUT: cnt_term = STEP_FRAMES - 8'd1;
            ST_HOLD:                   cnt_term = HOLD_FRAMES - 8'd1;
            ST_BLINK:                  cnt_term = BLINK_FRAMES - 8'd1;
            ST_GAP:                    cnt_term = GAP_FRAMES - 8'd1;
            default:                   cnt_term = 8'd0;
        endcase
    end

    // Everything advances only on frame_tick so the outputs stay constant across a frame.
    always_comb begin
        state_d      = state_q;
        org_x_d      = org_x_q;
        overlay_en_d = overlay_en_q;
        msg_sel_d    = msg_sel_q;
        cnt_clr      = 1'b0;

        if (bus.frame_tick) begin
            if (state_q == ST_IDLE) begin
                cnt_clr = 1'b1;
                if (bus.run) begin
                    state_d      = ST_SLIDE_IN;
                    overlay_en_d = 1'b1;
                end
            end else if (!bus.run) begin
                state_d      = ST_IDLE;
                org_x_d      = OFF_COL;
                overlay_en_d = 1'b0;
                cnt_clr      = 1'b1;
            end else begin
                case (state_q)
                    ST_SLIDE_IN: begin
                        if (cnt_at_term) begin
                            cnt_clr = 1'b1;
                            if (org_x_q > TARGET_COL) begin
                                org_x_d = org_x_q - 6'd1;
                            end
                            if (org_x_q <= TARGET_COL + 6'd1) begin
                                state_d = ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (cnt_at_term) begin
                            cnt_clr      = 1'b1;
                            state_d      = ST_BLINK;
                            overlay_en_d = 1'b1;
                        end
                    end
                    ST_BLINK: begin
                        if (cnt_at_term) begin
                            cnt_clr      = 1'b1;
                            state_d      = ST_SLIDE_OUT;
                            overlay_en_d = 1'b1;
                        end else begin
                            // Registered output must reflect the counter value of the coming frame.
                            overlay_en_d = ((cnt + 8'd1) & 8'd4) == 8'd0;
                        end
                    end
                    ST_SLIDE_OUT: begin
                        if (cnt_at_term) begin
                            cnt_clr = 1'b1;
                            if (org_x_q < OFF_COL) begin
                                org_x_d = org_x_q + 6'd1;
                            end
                            if (org_x_q + 6'd1 >= OFF_COL) begin
                                state_d      = ST_GAP;
                                overlay_en_d = 1'b0;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (cnt_at_term) begin
                            cnt_clr      = 1'b1;
                            state_d      = ST_SLIDE_IN;
                            overlay_en_d = 1'b1;
                            msg_sel_d    = msg_next(msg_sel_q, NUM_MSGS);
                        end
                    end
                    default: begin
                        state_d      = ST_IDLE;
                        org_x_d      = OFF_COL;
                        overlay_en_d = 1'b0;
                        cnt_clr      = 1'b1;
                    end
                endcase
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            org_x_q      <= OFF_COL;
            overlay_en_q <= 1'b0;
            msg_sel_q    <= 2'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            org_x_q      <= org_x_d;
            overlay_en_q <= overlay_en_d;
            msg_sel_q    <= msg_sel_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.org_x      = org_x_q;
    assign bus.overlay_en = overlay_en_q;
    assign bus.msg_sel    = msg_sel_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_overlay_sequencer.sv
// tb/tb_overlay_sequencer.sv - self-checking bench for overlay_sequencer (vector table, corner sequences, random vs model)
module tb_overlay_sequencer;
    import overlay_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic frame_tick = 1'b0;
    logic run = 1'b0;
    bit   chk_on = 1'b0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    overlay_sequencer_if if_a ();
    overlay_sequencer_if if_b ();

    assign if_a.frame_tick = frame_tick;
    assign if_a.run        = run;
    assign if_b.frame_tick = frame_tick;
    assign if_b.run        = run;

    overlay_sequencer u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    overlay_sequencer #(
        .TARGET_COL   (6'd10),
        .OFF_COL      (6'd14),
        .STEP_FRAMES  (8'd1),
        .HOLD_FRAMES  (8'd1),
        .BLINK_FRAMES (8'd8),
        .GAP_FRAMES   (8'd2),
        .NUM_MSGS     (2'd2)
    ) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    typedef struct {
        int off;
        int tgt;
        int step;
        int hold;
        int blink;
        int gap;
        int nmsg;
    } cfg_t;

    typedef struct {
        int ticks;
        bit run;
        int x;
        int en;
        int msg;
        int busy;
    } vec_t;

    cfg_t cfg [2];
    int   m_idle [2] = '{1, 1};
    int   m_t    [2] = '{0, 0};
    int   m_msg  [2] = '{0, 0};
    vec_t vecs [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // The sequence is a fixed timeline measured in ticks since entering SLIDE_IN.
    function automatic int cyc_len(input cfg_t c);
        return 2 * (c.off - c.tgt) * c.step + c.hold + c.blink + c.gap;
    endfunction

    task automatic exp_out(input cfg_t c, input int idle, input int t, output int x, output int en);
        int l_mv;
        int b1;
        int b2;
        int b3;
        l_mv = (c.off - c.tgt) * c.step;
        b1   = l_mv + c.hold;
        b2   = b1 + c.blink;
        b3   = b2 + l_mv;
        if (idle != 0) begin
            x = c.off; en = 0;
        end else if (t < l_mv) begin
            x = c.off - t / c.step; en = 1;
        end else if (t < b1) begin
            x = c.tgt; en = 1;
        end else if (t < b2) begin
            x = c.tgt; en = (((t - b1) / 4) % 2 == 0) ? 1 : 0;
        end else if (t < b3) begin
            x = c.tgt + (t - b2) / c.step; en = 1;
        end else begin
            x = c.off; en = 0;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_idle[i] = 1; m_t[i] = 0; m_msg[i] = 0;
            end else if (frame_tick) begin
                if (m_idle[i] != 0) begin
                    if (run) begin m_idle[i] = 0; m_t[i] = 0; end
                end else if (!run) begin
                    m_idle[i] = 1;
                end else begin
                    m_t[i] = m_t[i] + 1;
                    if (m_t[i] == cyc_len(cfg[i])) begin
                        m_t[i]   = 0;
                        m_msg[i] = (m_msg[i] + 1) % cfg[i].nmsg;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                int ex;
                int een;
                exp_out(cfg[i], m_idle[i], m_t[i], ex, een);
                if (i == 0) begin
                    check("a_model_org_x", int'(if_a.org_x), ex);
                    check("a_model_en", int'(if_a.overlay_en), een);
                    check("a_model_msg", int'(if_a.msg_sel), m_msg[0]);
                    check("a_model_busy", int'(if_a.busy), (m_idle[0] != 0) ? 0 : 1);
                end else begin
                    check("b_model_org_x", int'(if_b.org_x), ex);
                    check("b_model_en", int'(if_b.overlay_en), een);
                    check("b_model_msg", int'(if_b.msg_sel), m_msg[1]);
                    check("b_model_busy", int'(if_b.busy), (m_idle[1] != 0) ? 0 : 1);
                end
            end
        end
    end

    task automatic do_tick(input bit r);
        run = r;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int x, input int en, input int msg, input int busy);
        check({tag, "_org_x"}, int'(if_a.org_x), x);
        check({tag, "_en"}, int'(if_a.overlay_en), en);
        check({tag, "_msg"}, int'(if_a.msg_sel), msg);
        check({tag, "_busy"}, int'(if_a.busy), busy);
    endtask

    task automatic sync_reset_pulse();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        cfg[0].off = int'(DEF_OFF_COL);   cfg[0].tgt = int'(DEF_TARGET_COL);
        cfg[0].step = int'(DEF_STEP_FRAMES); cfg[0].hold = int'(DEF_HOLD_FRAMES);
        cfg[0].blink = int'(DEF_BLINK_FRAMES); cfg[0].gap = int'(DEF_GAP_FRAMES);
        cfg[0].nmsg = int'(DEF_NUM_MSGS);
        cfg[1].off = 14; cfg[1].tgt = 10; cfg[1].step = 1; cfg[1].hold = 1;
        cfg[1].blink = 8; cfg[1].gap = 2; cfg[1].nmsg = 2;

        vecs.push_back('{0,   0, 60, 0, 0, 0});
        vecs.push_back('{1,   0, 60, 0, 0, 0});
        vecs.push_back('{1,   1, 60, 1, 0, 1});
        vecs.push_back('{1,   1, 60, 1, 0, 1});
        vecs.push_back('{1,   1, 59, 1, 0, 1});
        vecs.push_back('{58,  1, 30, 1, 0, 1});
        vecs.push_back('{119, 1, 30, 1, 0, 1});
        vecs.push_back('{1,   1, 30, 1, 0, 1});
        vecs.push_back('{3,   1, 30, 1, 0, 1});
        vecs.push_back('{1,   1, 30, 0, 0, 1});
        vecs.push_back('{3,   1, 30, 0, 0, 1});
        vecs.push_back('{1,   1, 30, 1, 0, 1});
        vecs.push_back('{23,  1, 30, 0, 0, 1});
        vecs.push_back('{1,   1, 30, 1, 0, 1});
        vecs.push_back('{2,   1, 31, 1, 0, 1});
        vecs.push_back('{58,  1, 60, 0, 0, 1});
        vecs.push_back('{29,  1, 60, 0, 0, 1});
        vecs.push_back('{1,   1, 60, 1, 1, 1});
        vecs.push_back('{60,  1, 30, 1, 1, 1});
        vecs.push_back('{0,   0, 30, 1, 1, 1});
        vecs.push_back('{1,   0, 60, 0, 1, 0});
        vecs.push_back('{1,   0, 60, 0, 1, 0});
        vecs.push_back('{1,   1, 60, 1, 1, 1});

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_on = 1'b1;

        foreach (vecs[i]) begin
            run = vecs[i].run;
            if (vecs[i].ticks == 0) begin
                repeat (5) @(posedge clk);
                #1;
            end else begin
                repeat (vecs[i].ticks) do_tick(vecs[i].run);
            end
            check_a($sformatf("vec%0d", i), vecs[i].x, vecs[i].en, vecs[i].msg, vecs[i].busy);
        end

        // Three full cycles: msg_sel steps 0 -> 1 -> 2 -> 0 on each GAP to SLIDE_IN.
        sync_reset_pulse();
        do_tick(1'b1);
        check_a("msg_start", 60, 1, 0, 1);
        for (int k = 1; k <= 3; k++) begin
            repeat (302) do_tick(1'b1);
            check_a($sformatf("msg_cycle%0d", k), 60, 1, k % 3, 1);
        end

        // Asynchronous reset in the middle of BLINK, between clock edges.
        repeat (185) do_tick(1'b1);
        check_a("blink_pre_rst", 30, 0, 0, 1);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check_a("async_rst", 60, 0, 0, 0);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_tick(1'b1);
        check_a("rst_restart", 60, 1, 0, 1);

        // Single-frame steps and single-frame HOLD on the small configuration.
        sync_reset_pulse();
        do_tick(1'b1);
        check("b_step_start", int'(if_b.org_x), 14);
        for (int k = 1; k <= 4; k++) begin
            do_tick(1'b1);
            check($sformatf("b_step%0d", k), int'(if_b.org_x), 14 - k);
        end
        do_tick(1'b1);
        check("b_hold1_x", int'(if_b.org_x), 10);
        check("b_hold1_en", int'(if_b.overlay_en), 1);
        repeat (4) do_tick(1'b1);
        check("b_blink_off", int'(if_b.overlay_en), 0);
        check("b_blink_busy", int'(if_b.busy), 1);

        // Random ticks, run drops, multi-cycle ticks and occasional async resets.
        run = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            frame_tick = ($urandom_range(0, 3) == 0);
            run = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 2999) == 0) begin
                reset = 1'b1;
                #2;
                reset = 1'b0;
            end
        end
        frame_tick = 1'b0;
        @(posedge clk); #1;
        chk_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
